exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl_pkg.sv | 15 +
 rtl/exc_ctrl_if.sv | 26 ++
 rtl/exc_ctrl.sv | 108 ++++++++++
 tb/tb_exc_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/ERET sequencer: state encodings and the
// handler entry PC, which must match the vector used by the CPU top.
package exc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_VECTOR = 2'd2,
      ST_ERET   = 2'd3
   } exc_state_e;

   localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
   localparam int          CNT_W_DEF        = 16;

endpackage

// File: rtl/exc_ctrl_if.sv
// CP0/pipeline-facing bundle of the exception sequencer. The master side is the
// core (CP0, M-stage, bus bridge); the slave side is exc_ctrl.
interface exc_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic             req;
   logic             eret_m;
   logic [31:0]      epc;
   logic             bus_busy;
   logic             flush;
   logic             stall_all;
   logic             pc_redirect;
   logic [31:0]      pc_target;
   logic             exl_clr;
   logic [CNT_W-1:0] exc_count;

   modport master (
      output req, eret_m, epc, bus_busy,
      input  flush, stall_all, pc_redirect, pc_target, exl_clr, exc_count
   );

   modport slave (
      input  req, eret_m, epc, bus_busy,
      output flush, stall_all, pc_redirect, pc_target, exl_clr, exc_count
   );
endinterface

// File: rtl/exc_ctrl.sv
// Pipeline exception/ERET sequencer: kills the M instruction, drains the external
// bus, then redirects the PC to the handler or to the saved EPC.
//
// state  | meaning
// IDLE   | normal execution; watches req (priority) and eret_m
// DRAIN  | exception taken, pipeline frozen until the bus goes idle
// VECTOR | one-cycle redirect to the handler entry
// ERET   | one-cycle redirect to the EPC captured at eret
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
   parameter int          CNT_W        = CNT_W_DEF
) (
   input logic        clk,
   input logic        reset,
   exc_ctrl_if.slave  bus
);

   exc_state_e       state_q, state_d;
   logic [31:0]      epc_q, epc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_dly_q;

   logic             flush_c, stall_c, redir_c, exl_clr_c;
   logic [31:0]      target_c;
   logic             quiet;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         epc_q     <= '0;
         cnt_q     <= '0;
         rst_dly_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         epc_q     <= epc_d;
         cnt_q     <= cnt_d;
         rst_dly_q <= 1'b0;
      end
   end

   // Outputs stay low during reset and the first cycle after it; requests seen
   // in that window are not acted on so state and outputs never disagree.
   assign quiet = reset | rst_dly_q;

   always_comb begin
      state_d   = state_q;
      epc_d     = epc_q;
      cnt_d     = cnt_q;
      flush_c   = 1'b0;
      stall_c   = 1'b0;
      redir_c   = 1'b0;
      exl_clr_c = 1'b0;
      target_c  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (!quiet) begin
               if (bus.req) begin
                  flush_c = 1'b1;
                  state_d = bus.bus_busy ? ST_DRAIN : ST_VECTOR;
                  if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               end else if (bus.eret_m) begin
                  flush_c   = 1'b1;
                  exl_clr_c = 1'b1;
                  epc_d     = bus.epc;
                  state_d   = ST_ERET;
               end
            end
         end
         ST_DRAIN: begin
            flush_c = 1'b1;
            stall_c = 1'b1;
            if (!bus.bus_busy) state_d = ST_VECTOR;
         end
         ST_VECTOR: begin
            flush_c  = 1'b1;
            redir_c  = 1'b1;
            target_c = HANDLER_ADDR;
            state_d  = ST_IDLE;
         end
         ST_ERET: begin
            flush_c  = 1'b1;
            redir_c  = 1'b1;
            target_c = epc_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (reset) begin
         flush_c   = 1'b0;
         stall_c   = 1'b0;
         redir_c   = 1'b0;
         exl_clr_c = 1'b0;
         target_c  = '0;
      end
   end

   assign bus.flush       = flush_c;
   assign bus.stall_all   = stall_c;
   assign bus.pc_redirect = redir_c;
   assign bus.pc_target   = target_c;
   assign bus.exl_clr     = exl_clr_c;
   assign bus.exc_count   = cnt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed stimulus, redirect targets checked by a
// scoreboard queue, plus a CNT_W=2 twin for counter saturation.
module tb_exc_ctrl;
   import exc_ctrl_pkg::*;

   localparam logic [31:0] HADDR = 32'h0000_4180;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];

   exc_ctrl_if #(.CNT_W(16)) u_if ();
   exc_ctrl_if #(.CNT_W(2))  u_if2 ();

   assign u_if2.req      = u_if.req;
   assign u_if2.eret_m   = u_if.eret_m;
   assign u_if2.epc      = u_if.epc;
   assign u_if2.bus_busy = u_if.bus_busy;

   exc_ctrl #(.HANDLER_ADDR(HADDR), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   exc_ctrl #(.HANDLER_ADDR(HADDR), .CNT_W(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if2.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Checks the combinational flags of the current cycle at the falling edge.
   task automatic flags(input string name, input logic fl, input logic st, input logic ex);
      @(negedge clk);
      chk({name, ".flush"}, {31'd0, u_if.flush}, {31'd0, fl});
      chk({name, ".stall"}, {31'd0, u_if.stall_all}, {31'd0, st});
      chk({name, ".exl_clr"}, {31'd0, u_if.exl_clr}, {31'd0, ex});
   endtask

   // Monitor: every redirect must match the oldest expected target.
   always @(negedge clk) begin
      if (u_if.pc_redirect) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_redirect", u_if.pc_target, 32'hFFFF_FFFF);
         end else begin
            chk("redirect_target", u_if.pc_target, exp_q.pop_front());
         end
      end else begin
         chk("idle_target_zero", u_if.pc_target, 32'd0);
      end
   end

   initial begin
      u_if.req = 1'b0;
      u_if.eret_m = 1'b0;
      u_if.epc = 32'd0;
      u_if.bus_busy = 1'b0;

      // reset asserted, then released; outputs must stay low
      cyc(); cyc();
      flags("in_reset", 1'b0, 1'b0, 1'b0);
      chk("reset_count", 32'(u_if.exc_count), 32'd0);
      cyc();
      reset = 1'b0;
      flags("post_reset", 1'b0, 1'b0, 1'b0);
      cyc();
      flags("idle", 1'b0, 1'b0, 1'b0);

      // exception with bus idle
      cyc();
      u_if.req = 1'b1;
      exp_q.push_back(HADDR);
      flags("exc_take", 1'b1, 1'b0, 1'b0);
      cyc();
      u_if.req = 1'b0;
      flags("exc_vector", 1'b1, 1'b0, 1'b0);
      chk("count_after_exc1", 32'(u_if.exc_count), 32'd1);
      cyc();
      flags("exc_back_idle", 1'b0, 1'b0, 1'b0);

      // exception with bus busy for two drain cycles, then one idle drain cycle
      cyc();
      u_if.req = 1'b1;
      u_if.bus_busy = 1'b1;
      exp_q.push_back(HADDR);
      flags("drain_take", 1'b1, 1'b0, 1'b0);
      cyc();
      u_if.req = 1'b0;
      flags("drain_c6", 1'b1, 1'b1, 1'b0);
      cyc();
      flags("drain_c7", 1'b1, 1'b1, 1'b0);
      cyc();
      u_if.bus_busy = 1'b0;
      flags("drain_c8", 1'b1, 1'b1, 1'b0);
      cyc();
      flags("drain_vector", 1'b1, 1'b0, 1'b0);
      chk("count_after_exc2", 32'(u_if.exc_count), 32'd2);
      cyc();
      flags("drain_back_idle", 1'b0, 1'b0, 1'b0);

      // eret: target comes from EPC captured at eret, not the later value
      cyc();
      u_if.epc = 32'h0000_3010;
      u_if.eret_m = 1'b1;
      exp_q.push_back(32'h0000_3010);
      flags("eret_take", 1'b1, 1'b0, 1'b1);
      cyc();
      u_if.eret_m = 1'b0;
      u_if.epc = 32'h0000_5555;
      flags("eret_redirect", 1'b1, 1'b0, 1'b0);
      chk("count_after_eret", 32'(u_if.exc_count), 32'd2);
      cyc();
      flags("eret_back_idle", 1'b0, 1'b0, 1'b0);

      // simultaneous req/eret: exception wins; req during VECTOR is ignored
      cyc();
      u_if.req = 1'b1;
      u_if.eret_m = 1'b1;
      exp_q.push_back(HADDR);
      flags("simul_take", 1'b1, 1'b0, 1'b0);
      cyc();
      u_if.eret_m = 1'b0;
      flags("simul_vector_req", 1'b1, 1'b0, 1'b0);
      cyc();
      u_if.req = 1'b0;
      flags("simul_back_idle", 1'b0, 1'b0, 1'b0);
      chk("count_after_simul", 32'(u_if.exc_count), 32'd3);
      chk("count2_after_three", 32'(u_if2.exc_count), 32'd3);

      // reset in the middle of a drain abandons the redirect
      cyc();
      u_if.req = 1'b1;
      u_if.bus_busy = 1'b1;
      flags("rst_drain_take", 1'b1, 1'b0, 1'b0);
      cyc();
      u_if.req = 1'b0;
      flags("rst_drain_stall", 1'b1, 1'b1, 1'b0);
      cyc();
      reset = 1'b1;
      flags("rst_drain_in_reset", 1'b0, 1'b0, 1'b0);
      cyc();
      reset = 1'b0;
      flags("rst_drain_after", 1'b0, 1'b0, 1'b0);
      chk("rst_drain_count", 32'(u_if.exc_count), 32'd0);
      chk("rst_drain_count2", 32'(u_if2.exc_count), 32'd0);
      cyc();
      u_if.bus_busy = 1'b0;
      flags("rst_drain_idle", 1'b0, 1'b0, 1'b0);
      cyc(); cyc();

      // four exceptions: the 2-bit counter holds at 3
      for (int i = 1; i <= 4; i++) begin
         cyc();
         u_if.req = 1'b1;
         exp_q.push_back(HADDR);
         cyc();
         u_if.req = 1'b0;
         cyc();
         @(negedge clk);
         chk("sat_count16", 32'(u_if.exc_count), 32'(i));
         chk("sat_count2", 32'(u_if2.exc_count), (i >= 3) ? 32'd3 : 32'(i));
      end

      cyc(); cyc();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
